ddr_stream_wr_packer: RTL and testbench
=======================================

// Module: ddr_stream_wr_packer
// PURPOSE
// Upstream feeder for one write port of the four-port DDR controller (user stream / Ethernet ports).
// Accepts a 64-bit AXI-style stream and packs it into 256-bit beats.
// Issues each pair of beats as one DDR write burst on the controller's port interface (valid/addr/ack).
// Ping-pong 512-bit buffering lets the stream keep flowing while the previous burst drains.
// PARAMETERS
// ADDR_STEP  8  app address increment per 2-beat (512-bit) burst
// PORTS
// i_clk            in   1    clock (same clock as the DDR controller)
// i_rst_n          in   1    asynchronous active-low reset
// i_start          in   1    1-cycle pulse; loads i_base_addr and arms a transfer; ignored while o_busy
// i_base_addr      in   32   DDR address of the first burst
// i_tdata          in   64   stream data; word k of a burst lands at bits [64*(k%4)+:64] of beat k/4
// i_tvalid         in   1    stream valid
// i_tlast          in   1    last word of the transfer
// o_tready         out  1    stream ready
// o_wr_data        out  256  write beat to controller port
// o_wr_data_be     out  32   byte mask to controller, 1 = byte NOT written
// o_wr_data_valid  out  1    beat valid; held until o_wr_ack-qualified
// o_wr_addr        out  32   burst address, stable for both beats
// i_wr_ack         in   1    controller accepted current beat (may be combinational off valid)
// o_busy           out  1    armed and transfer not yet drained
// o_done           out  1    1-cycle pulse when the last burst's beat 1 is acked
// o_burst_cnt      out  16   bursts completed since last i_start (wraps at 2^16)
// BEHAVIOUR
// Reset: all outputs 0, both buffers empty, fill/drain pointers 0, FSM IDLE, address 0.
// i_start when !o_busy: addr<=i_base_addr, o_burst_cnt<=0, o_busy<=1 next cycle.
// o_tready = o_busy & fill buffer not full & !last_seen; transfer when i_tvalid & o_tready.
// Fill side: word counter 0..7 per buffer; per-word byte-mask bits cleared on write.
// - Buffer starts each fill with mask all 1s.
// - Word 7 written, or i_tlast accepted: buffer marked full; fill pointer toggles; counter <= 0.
// - i_tlast mid-burst: unwritten words stay masked (1s); data content of masked bytes is don't-care.
// - After i_tlast: last_seen=1; no further words accepted until next i_start.
// Both buffers full: o_tready=0 (no word is dropped or overwritten).
// Drain FSM (all outputs registered, no path from i_wr_ack to o_wr_data_valid in the same cycle):
// - IDLE: drain buffer full -> BEAT0 next cycle; o_wr_data_valid=1, beat 0 data/mask, o_wr_addr=addr.
// - BEAT0: on i_wr_ack -> BEAT1; beat 1 data/mask presented the next cycle, valid stays 1.
// - BEAT1: on i_wr_ack:
//   - buffer released, drain pointer toggles, addr<=addr+ADDR_STEP (mod 2^32), o_burst_cnt++.
//   - If another buffer is full -> BEAT0 directly (valid stays 1), else IDLE (valid 0).
// Ack is only honoured while o_wr_data_valid=1; ack with valid low is ignored.
// Latency: buffer marked full at edge N -> valid high after edge N+1 (1 cycle).
// Simultaneous: fill of one buffer and release of the other in the same cycle are both honoured.
// - A buffer released in cycle N may be refilled from cycle N+1.
// o_done: pulses with the BEAT1 ack of the burst holding i_tlast; o_busy<=0 same edge.
// - i_tlast on word 7 and i_tlast mid-burst behave identically.
// Empty transfer is impossible: a burst is emitted only if at least one word was written.
// i_rst_n low at any time: immediate return to reset values.
// - In-flight beat abandoned; the controller port sees valid drop asynchronously.
// TESTING
// 1. start base=0x100; 16 words, tlast on word 15:
//    two bursts at addr 0x100, 0x108; all masks 0; o_done once; o_burst_cnt=2.
// 2. 5 words, tlast on word 4: one burst; beat0 mask 0; beat1 mask 32'hFFFF_FF00; o_done after beat1 ack.
// 3. ack held 0, stream 24 words:
//    exactly 16 accepted then o_tready=0; release ack -> 3 bursts, data order preserved.
// 4. ack asserted same cycle as every valid: back-to-back beats, no valid bubble between bursts 1 and 2.
// 5. i_start pulse while o_busy=1: base/count unchanged; base=0xFFFF_FFF8, 16 words -> second addr 0x0.
// 6. i_rst_n low during BEAT1: outputs 0 asynchronously; after release o_tready=0 until next i_start.

Source files
------------

// File: rtl/ddr_stream_wr_packer.sv
// Packs a 64-bit stream into 512-bit ping-pong buffers and drains each buffer
// as a two-beat 256-bit write burst on a DDR controller port.
module ddr_stream_wr_packer #(
    parameter int unsigned ADDR_STEP = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [31:0]  i_base_addr,
    input  logic [63:0]  i_tdata,
    input  logic         i_tvalid,
    input  logic         i_tlast,
    output logic         o_tready,
    output logic [255:0] o_wr_data,
    output logic [31:0]  o_wr_data_be,
    output logic         o_wr_data_valid,
    output logic [31:0]  o_wr_addr,
    input  logic         i_wr_ack,
    output logic         o_busy,
    output logic         o_done,
    output logic [15:0]  o_burst_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1
    } state_t;

    state_t       state;
    logic [511:0] buf_data [2];
    logic [63:0]  buf_be   [2];
    logic [1:0]   buf_full;
    logic [1:0]   buf_last;
    logic         fill_ptr;
    logic         drain_ptr;
    logic [2:0]   word_cnt;
    logic         last_seen;
    logic [31:0]  addr;

    logic         accept;
    logic         close_buf;
    logic         ack;
    logic [63:0]  fill_be;
    logic [31:0]  addr_next;

    always_comb begin
        o_tready  = o_busy & ~buf_full[fill_ptr] & ~last_seen;
        accept    = i_tvalid & o_tready;
        close_buf = accept & ((word_cnt == 3'd7) | i_tlast);
        ack       = i_wr_ack & o_wr_data_valid;
        addr_next = addr + 32'(ADDR_STEP);
        // First word of a fill re-arms the whole mask so stale bits never leak.
        fill_be   = (word_cnt == 3'd0) ? '1 : buf_be[fill_ptr];
        fill_be[{word_cnt, 3'b000} +: 8] = '0;
    end

    // Payload storage needs no reset: the byte mask marks unwritten lanes.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            buf_data[fill_ptr][{word_cnt, 6'b000000} +: 64] <= i_tdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            buf_be[0]       <= '0;
            buf_be[1]       <= '0;
            buf_full        <= '0;
            buf_last        <= '0;
            fill_ptr        <= 1'b0;
            drain_ptr       <= 1'b0;
            word_cnt        <= '0;
            last_seen       <= 1'b0;
            addr            <= '0;
            o_wr_data       <= '0;
            o_wr_data_be    <= '0;
            o_wr_data_valid <= 1'b0;
            o_wr_addr       <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_burst_cnt     <= '0;
        end else begin
            o_done <= 1'b0;

            if (i_start && !o_busy) begin
                addr        <= i_base_addr;
                o_burst_cnt <= '0;
                o_busy      <= 1'b1;
                last_seen   <= 1'b0;
                word_cnt    <= '0;
                fill_ptr    <= 1'b0;
                drain_ptr   <= 1'b0;
            end

            if (accept) begin
                buf_be[fill_ptr] <= fill_be;
                if (close_buf) begin
                    buf_full[fill_ptr] <= 1'b1;
                    buf_last[fill_ptr] <= i_tlast;
                    fill_ptr           <= ~fill_ptr;
                    word_cnt           <= '0;
                end else begin
                    word_cnt <= word_cnt + 3'd1;
                end
                if (i_tlast) begin
                    last_seen <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (buf_full[drain_ptr]) begin
                        state           <= ST_BEAT0;
                        o_wr_data_valid <= 1'b1;
                        o_wr_data       <= buf_data[drain_ptr][255:0];
                        o_wr_data_be    <= buf_be[drain_ptr][31:0];
                        o_wr_addr       <= addr;
                    end
                end
                ST_BEAT0: begin
                    if (ack) begin
                        state        <= ST_BEAT1;
                        o_wr_data    <= buf_data[drain_ptr][511:256];
                        o_wr_data_be <= buf_be[drain_ptr][63:32];
                    end
                end
                ST_BEAT1: begin
                    if (ack) begin
                        buf_full[drain_ptr] <= 1'b0;
                        drain_ptr           <= ~drain_ptr;
                        addr                <= addr_next;
                        o_burst_cnt         <= o_burst_cnt + 16'd1;
                        if (buf_last[drain_ptr]) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end
                        // Chain straight into the other buffer to avoid a valid bubble.
                        if (buf_full[~drain_ptr]) begin
                            state        <= ST_BEAT0;
                            o_wr_data    <= buf_data[~drain_ptr][255:0];
                            o_wr_data_be <= buf_be[~drain_ptr][31:0];
                            o_wr_addr    <= addr_next;
                        end else begin
                            state           <= ST_IDLE;
                            o_wr_data_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    o_wr_data_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_stream_wr_packer.sv
// Directed self-checking bench for ddr_stream_wr_packer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ddr_stream_wr_packer;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_start = 1'b0;
    logic [31:0]  i_base_addr = '0;
    logic [63:0]  i_tdata = '0;
    logic         i_tvalid = 1'b0;
    logic         i_tlast = 1'b0;
    logic         o_tready;
    logic [255:0] o_wr_data;
    logic [31:0]  o_wr_data_be;
    logic         o_wr_data_valid;
    logic [31:0]  o_wr_addr;
    logic         i_wr_ack = 1'b0;
    logic         o_busy;
    logic         o_done;
    logic [15:0]  o_burst_cnt;

    int checks = 0;
    int failures = 0;

    logic [255:0] cap_data [16];
    logic [31:0]  cap_be   [16];
    logic [31:0]  cap_addr [16];
    int           cap_cyc  [16];
    int           nbeats;
    int           done_cnt;
    logic         busy_at_done;
    int           sent_at_hold;
    logic         tready_at_hold;
    logic         timed_out;

    always #5 i_clk = ~i_clk;

    ddr_stream_wr_packer #(.ADDR_STEP(8)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_tdata        (i_tdata),
        .i_tvalid       (i_tvalid),
        .i_tlast        (i_tlast),
        .o_tready       (o_tready),
        .o_wr_data      (o_wr_data),
        .o_wr_data_be   (o_wr_data_be),
        .o_wr_data_valid(o_wr_data_valid),
        .o_wr_addr      (o_wr_addr),
        .i_wr_ack       (i_wr_ack),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_burst_cnt    (o_burst_cnt)
    );

    function automatic logic [63:0] word_of(input logic [7:0] tag, input int w);
        logic [31:0] lo;
        lo = 32'(w) * 32'h0101_0101 + 32'h7;
        return {8'hD0, tag, 16'h5A5A, lo};
    endfunction

    task automatic do_start(input logic [31:0] base);
        @(negedge i_clk);
        i_start     = 1'b1;
        i_base_addr = base;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Streams n words (tlast on the last), acks every valid beat from cycle
    // 'hold' on, optionally pulses i_start at cycle start_at, stops on o_done.
    task automatic run_stream(input logic [7:0] tag, input int n, input int hold,
                              input int start_at, input logic [31:0] start_base,
                              input int budget);
        int sent;
        sent      = 0;
        nbeats    = 0;
        done_cnt  = 0;
        timed_out = 1'b1;
        sent_at_hold   = -1;
        tready_at_hold = 1'bx;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge i_clk);
            if (o_done) begin
                done_cnt++;
                busy_at_done = o_busy;
                timed_out    = 1'b0;
                break;
            end
            i_start     = (cyc == start_at);
            i_base_addr = start_base;
            if (sent < n) begin
                i_tvalid = 1'b1;
                i_tdata  = word_of(tag, sent);
                i_tlast  = (sent == n - 1);
                if (o_tready) sent++;
            end else begin
                i_tvalid = 1'b0;
                i_tlast  = 1'b0;
            end
            if (cyc + 1 == hold) begin
                sent_at_hold   = sent;
                tready_at_hold = o_tready;
            end
            i_wr_ack = (cyc >= hold) && o_wr_data_valid;
            if (i_wr_ack && nbeats < 16) begin
                cap_data[nbeats] = o_wr_data;
                cap_be[nbeats]   = o_wr_data_be;
                cap_addr[nbeats] = o_wr_addr;
                cap_cyc[nbeats]  = cyc;
                nbeats++;
            end
        end
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        i_wr_ack = 1'b0;
        i_start  = 1'b0;
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if ({o_tready, o_wr_data_valid, o_busy, o_done} !== 4'b0000 ||
            o_wr_data !== '0 || o_wr_data_be !== '0 || o_wr_addr !== '0 || o_burst_cnt !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got rdy/vld/busy/done=%b%b%b%b addr=%0h cnt=%0d required all 0",
                     o_tready, o_wr_data_valid, o_busy, o_done, o_wr_addr, o_burst_cnt);
        end
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0 || o_tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b tready=%b required 0 0", o_busy, o_tready);
        end
    endtask

    task automatic test_two_bursts;
        do_start(32'h100);
        checks++;
        if (o_busy !== 1'b1 || o_burst_cnt !== 16'd0 || o_tready !== 1'b1) begin
            failures++;
            $display("FAIL t1_armed: got busy=%b cnt=%0d tready=%b required 1 0 1", o_busy, o_burst_cnt, o_tready);
        end
        run_stream(8'h01, 16, 0, -1, 32'h0, 300);
        checks++;
        if (timed_out !== 1'b0 || nbeats != 4) begin
            failures++;
            $display("FAIL t1_beats: got beats=%0d timeout=%b required 4 0", nbeats, timed_out);
        end
        checks++;
        if (cap_addr[0] !== 32'h100 || cap_addr[1] !== 32'h100 ||
            cap_addr[2] !== 32'h108 || cap_addr[3] !== 32'h108) begin
            failures++;
            $display("FAIL t1_addr: got %0h %0h %0h %0h required 100 100 108 108",
                     cap_addr[0], cap_addr[1], cap_addr[2], cap_addr[3]);
        end
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 4; l++) begin
                int w;
                w = (b / 2) * 8 + (b % 2) * 4 + l;
                checks++;
                if (cap_data[b][64*l +: 64] !== word_of(8'h01, w) || cap_be[b][8*l +: 8] !== 8'h00) begin
                    failures++;
                    $display("FAIL t1_data b%0d l%0d: got %0h be %0h required %0h be 0",
                             b, l, cap_data[b][64*l +: 64], cap_be[b][8*l +: 8], word_of(8'h01, w));
                end
            end
        end
        checks++;
        if (done_cnt != 1 || busy_at_done !== 1'b0 || o_burst_cnt !== 16'd2) begin
            failures++;
            $display("FAIL t1_done: got done=%0d busy=%b cnt=%0d required 1 0 2", done_cnt, busy_at_done, o_burst_cnt);
        end
        @(negedge i_clk);
        checks++;
        if (o_done !== 1'b0) begin
            failures++;
            $display("FAIL t1_done_pulse: got done=%b one cycle later required 0", o_done);
        end
    endtask

    task automatic test_partial;
        do_start(32'h2000);
        run_stream(8'h02, 5, 0, -1, 32'h0, 300);
        checks++;
        if (timed_out !== 1'b0 || nbeats != 2 || done_cnt != 1 || o_burst_cnt !== 16'd1) begin
            failures++;
            $display("FAIL t2_count: got beats=%0d done=%0d cnt=%0d required 2 1 1", nbeats, done_cnt, o_burst_cnt);
        end
        checks++;
        if (cap_be[0] !== 32'h0 || cap_be[1] !== 32'hFFFF_FF00) begin
            failures++;
            $display("FAIL t2_mask: got %0h %0h required 0 ffffff00", cap_be[0], cap_be[1]);
        end
        for (int w = 0; w < 5; w++) begin
            checks++;
            if (cap_data[w / 4][64*(w % 4) +: 64] !== word_of(8'h02, w)) begin
                failures++;
                $display("FAIL t2_data w%0d: got %0h required %0h", w, cap_data[w / 4][64*(w % 4) +: 64], word_of(8'h02, w));
            end
        end
        checks++;
        if (cap_addr[1] !== 32'h2000) begin
            failures++;
            $display("FAIL t2_addr: got %0h required 2000", cap_addr[1]);
        end
    endtask

    task automatic test_backpressure;
        do_start(32'h400);
        run_stream(8'h03, 24, 40, -1, 32'h0, 400);
        checks++;
        if (sent_at_hold != 16 || tready_at_hold !== 1'b0) begin
            failures++;
            $display("FAIL t3_stall: got accepted=%0d tready=%b required 16 0", sent_at_hold, tready_at_hold);
        end
        checks++;
        if (timed_out !== 1'b0 || nbeats != 6 || o_burst_cnt !== 16'd3) begin
            failures++;
            $display("FAIL t3_beats: got beats=%0d cnt=%0d required 6 3", nbeats, o_burst_cnt);
        end
        checks++;
        if (cap_addr[0] !== 32'h400 || cap_addr[2] !== 32'h408 || cap_addr[5] !== 32'h410) begin
            failures++;
            $display("FAIL t3_addr: got %0h %0h %0h required 400 408 410", cap_addr[0], cap_addr[2], cap_addr[5]);
        end
        for (int b = 0; b < nbeats; b++) begin
            for (int l = 0; l < 4; l++) begin
                int w;
                w = (b / 2) * 8 + (b % 2) * 4 + l;
                checks++;
                if (cap_data[b][64*l +: 64] !== word_of(8'h03, w) || cap_be[b][8*l +: 8] !== 8'h00) begin
                    failures++;
                    $display("FAIL t3_order b%0d l%0d: got %0h be %0h required %0h be 0",
                             b, l, cap_data[b][64*l +: 64], cap_be[b][8*l +: 8], word_of(8'h03, w));
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        do_start(32'h800);
        run_stream(8'h04, 16, 20, -1, 32'h0, 300);
        checks++;
        if (timed_out !== 1'b0 || nbeats != 4) begin
            failures++;
            $display("FAIL t4_beats: got beats=%0d required 4", nbeats);
        end
        checks++;
        if (cap_cyc[1] - cap_cyc[0] != 1 || cap_cyc[2] - cap_cyc[1] != 1 || cap_cyc[3] - cap_cyc[2] != 1) begin
            failures++;
            $display("FAIL t4_bubble: got beat cycles %0d %0d %0d %0d required consecutive",
                     cap_cyc[0], cap_cyc[1], cap_cyc[2], cap_cyc[3]);
        end
        checks++;
        if (cap_addr[1] !== 32'h800 || cap_addr[2] !== 32'h808 ||
            cap_data[2][63:0] !== word_of(8'h04, 8) || cap_data[1][255:192] !== word_of(8'h04, 7)) begin
            failures++;
            $display("FAIL t4_switch: got addr %0h %0h required 800 808 with words 7 and 8", cap_addr[1], cap_addr[2]);
        end
    endtask

    task automatic test_start_while_busy;
        do_start(32'hFFFF_FFF8);
        run_stream(8'h05, 16, 0, 13, 32'h1234, 300);
        checks++;
        if (timed_out !== 1'b0 || nbeats != 4 || o_burst_cnt !== 16'd2) begin
            failures++;
            $display("FAIL t5_count: got beats=%0d cnt=%0d required 4 2", nbeats, o_burst_cnt);
        end
        checks++;
        if (cap_addr[0] !== 32'hFFFF_FFF8 || cap_addr[3] !== 32'h0) begin
            failures++;
            $display("FAIL t5_addr: got %0h %0h required fffffff8 0", cap_addr[0], cap_addr[3]);
        end
    endtask

    task automatic test_reset_midburst;
        bit seen;
        do_start(32'h40);
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            i_tvalid = 1'b1;
            i_tdata  = word_of(8'h06, k);
        end
        @(negedge i_clk);
        i_tvalid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (o_wr_data_valid) seen = 1'b1;
            else @(negedge i_clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL t6_valid: got valid=%b required 1 within 10 cycles", o_wr_data_valid);
        end
        i_wr_ack = 1'b1;
        @(negedge i_clk);
        i_wr_ack = 1'b0;
        checks++;
        if (o_wr_data_valid !== 1'b1 || o_wr_data[63:0] !== word_of(8'h06, 4)) begin
            failures++;
            $display("FAIL t6_beat1: got valid=%b data=%0h required 1 %0h", o_wr_data_valid, o_wr_data[63:0], word_of(8'h06, 4));
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if (o_wr_data_valid !== 1'b0 || o_busy !== 1'b0 || o_wr_addr !== '0 || o_wr_data !== '0 || o_tready !== 1'b0) begin
            failures++;
            $display("FAIL t6_async: got valid=%b busy=%b addr=%0h tready=%b required all 0",
                     o_wr_data_valid, o_busy, o_wr_addr, o_tready);
        end
        @(negedge i_clk);
        i_rst_n  = 1'b1;
        i_tvalid = 1'b1;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_tready !== 1'b0 || o_busy !== 1'b0 || o_wr_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL t6_after: got tready=%b busy=%b valid=%b required 0 0 0", o_tready, o_busy, o_wr_data_valid);
        end
        i_tvalid = 1'b0;
        do_start(32'h80);
        run_stream(8'h07, 8, 0, -1, 32'h0, 200);
        checks++;
        if (timed_out !== 1'b0 || nbeats != 2 || cap_addr[0] !== 32'h80 ||
            cap_data[0][63:0] !== word_of(8'h07, 0) || cap_be[1] !== 32'h0 || o_burst_cnt !== 16'd1) begin
            failures++;
            $display("FAIL t6_recover: got beats=%0d addr=%0h cnt=%0d required 2 80 1", nbeats, cap_addr[0], o_burst_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_two_bursts();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_start_while_busy();
        test_reset_midburst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
